// File: rtl/can_rx_frame.sv
// can_rx_frame: CAN 2.0A base-frame receiver (hard sync, destuff, CRC-15).
// Define CAN_RX_ACK_EN to drive the ACK slot dominant on a CRC match.
module can_rx_frame #(
  parameter int BIT_TICKS = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        can_rx,
  input  logic        rx_start,
  output logic        can_tx,
  output logic [10:0] rx_id,
  output logic [3:0]  rx_dlc,
  output logic [7:0]  rx_data,
  output logic        rx_data_valid,
  output logic        frame_done,
  output logic        crc_err,
  output logic        stuff_err,
  output logic        form_err
);

  localparam int CW = $clog2(BIT_TICKS);
  localparam logic [CW-1:0] HALF = CW'(BIT_TICKS / 2);
  localparam logic [CW-1:0] LAST = CW'(BIT_TICKS - 1);
  localparam logic [14:0] POLY = 15'h4599;

  typedef enum logic [3:0] {
    S_IDLE, S_SOF, S_ID, S_CTRL, S_DLC, S_DATA,
    S_CRC, S_CRCDEL, S_ACK, S_ACKDEL, S_EOF, S_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sync_q;
  logic          rxp_q;
  logic [5:0]    bcnt_q, bcnt_d;
  logic          run_val_q, run_val_d;
  logic [2:0]    run_cnt_q, run_cnt_d;
  logic [14:0]   crc_q, crc_d;
  logic [14:0]   crc_rx_q, crc_rx_d;
  logic [9:0]    sh_q, sh_d;
  logic [3:0]    nb_q, nb_d;
  logic          rtr_q, rtr_d;
  logic [3:0]    idle_q, idle_d;
  logic [10:0]   id_q, id_d;
  logic [3:0]    dlc_q, dlc_d;
  logic [7:0]    data_q, data_d;
  logic          dv_q, dv_d;
  logic          done_q, done_d;
  logic          crce_q, crce_d;
  logic          stfe_q, stfe_d;
  logic          frme_q, frme_d;

  logic       rx_s, sample, wrap;
  logic       stuff_act, is_stuff, crc_in;
  logic [3:0] dlc_w;

  assign rx_s   = sync_q[1];
  assign wrap   = (cnt_q == LAST);
  assign sample = (cnt_q == HALF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      rxp_q     <= 1'b0;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bcnt_q    <= '0;
      run_val_q <= 1'b0;
      run_cnt_q <= '0;
      crc_q     <= '0;
      crc_rx_q  <= '0;
      sh_q      <= '0;
      nb_q      <= '0;
      rtr_q     <= 1'b0;
      idle_q    <= '0;
      id_q      <= '0;
      dlc_q     <= '0;
      data_q    <= '0;
      dv_q      <= 1'b0;
      done_q    <= 1'b0;
      crce_q    <= 1'b0;
      stfe_q    <= 1'b0;
      frme_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], can_rx};
      rxp_q     <= rx_s;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bcnt_q    <= bcnt_d;
      run_val_q <= run_val_d;
      run_cnt_q <= run_cnt_d;
      crc_q     <= crc_d;
      crc_rx_q  <= crc_rx_d;
      sh_q      <= sh_d;
      nb_q      <= nb_d;
      rtr_q     <= rtr_d;
      idle_q    <= idle_d;
      id_q      <= id_d;
      dlc_q     <= dlc_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
      done_q    <= done_d;
      crce_q    <= crce_d;
      stfe_q    <= stfe_d;
      frme_q    <= frme_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = wrap ? '0 : cnt_q + CW'(1);
    bcnt_d    = bcnt_q;
    run_val_d = run_val_q;
    run_cnt_d = run_cnt_q;
    crc_d     = crc_q;
    crc_rx_d  = crc_rx_q;
    sh_d      = sh_q;
    nb_d      = nb_q;
    rtr_d     = rtr_q;
    idle_d    = idle_q;
    id_d      = id_q;
    dlc_d     = dlc_q;
    data_d    = data_q;
    dv_d      = 1'b0;
    done_d    = 1'b0;
    crce_d    = 1'b0;
    stfe_d    = 1'b0;
    frme_d    = 1'b0;
    dlc_w     = {sh_q[2:0], rx_s};
    stuff_act = state_q inside {S_SOF, S_ID, S_CTRL, S_DLC,
                                S_DATA, S_CRC, S_CRCDEL};
    is_stuff  = stuff_act && (run_cnt_q == 3'd5);
    crc_in    = state_q inside {S_SOF, S_ID, S_CTRL, S_DLC, S_DATA};

    if (state_q == S_IDLE) begin
      if (rx_start && rxp_q && !rx_s) begin
        state_d   = S_SOF;
        cnt_d     = '0;
        run_val_d = 1'b0;
        run_cnt_d = '0;
        crc_d     = '0;
      end
    end else if (sample && is_stuff) begin
      if (rx_s == run_val_q) begin
        stfe_d  = 1'b1;
        state_d = S_WAIT;
      end else begin
        run_val_d = rx_s;
        run_cnt_d = 3'd1;
      end
    end else if (sample) begin
      bcnt_d = bcnt_q + 6'd1;
      sh_d   = {sh_q[8:0], rx_s};
      // CRC_DEL only consumes a trailing stuff bit; it never extends a run
      if (stuff_act && state_q != S_CRCDEL) begin
        run_cnt_d = (rx_s == run_val_q) ? run_cnt_q + 3'd1 : 3'd1;
        run_val_d = rx_s;
      end
      if (crc_in)
        crc_d = {crc_q[13:0], 1'b0} ^ ((rx_s ^ crc_q[14]) ? POLY : '0);
      unique case (state_q)
        S_SOF:
          state_d = rx_s ? S_IDLE : S_ID;
        S_ID:
          if (bcnt_q == 6'd10) begin
            id_d    = {sh_q, rx_s};
            state_d = S_CTRL;
          end
        S_CTRL:
          if (bcnt_q == 6'd0) begin
            rtr_d = rx_s;
          end else if (bcnt_q == 6'd1) begin
            if (rx_s) begin
              frme_d  = 1'b1;
              state_d = S_WAIT;
            end
          end else begin
            state_d = S_DLC;
          end
        S_DLC:
          if (bcnt_q == 6'd3) begin
            dlc_d   = dlc_w;
            nb_d    = rtr_q ? 4'd0 : (dlc_w > 4'd8 ? 4'd8 : dlc_w);
            state_d = (rtr_q || dlc_w == 4'd0) ? S_CRC : S_DATA;
          end
        S_DATA:
          if (bcnt_q[2:0] == 3'd7) begin
            data_d = {sh_q[6:0], rx_s};
            dv_d   = 1'b1;
            if ({1'b0, bcnt_q[5:3]} + 4'd1 == nb_q)
              state_d = S_CRC;
          end
        S_CRC: begin
          crc_rx_d = {crc_rx_q[13:0], rx_s};
          if (bcnt_q == 6'd14)
            state_d = S_CRCDEL;
        end
        S_CRCDEL:
          if (crc_rx_q != crc_q) begin
            crce_d  = 1'b1;
            state_d = S_WAIT;
          end else if (!rx_s) begin
            frme_d  = 1'b1;
            state_d = S_WAIT;
          end else begin
            state_d = S_ACK;
          end
        S_ACK:
          state_d = S_ACKDEL;
        S_ACKDEL:
          if (!rx_s) begin
            frme_d  = 1'b1;
            state_d = S_WAIT;
          end else begin
            state_d = S_EOF;
          end
        S_EOF:
          if (!rx_s) begin
            frme_d  = 1'b1;
            state_d = S_WAIT;
          end else if (bcnt_q == 6'd6) begin
            done_d  = 1'b1;
            state_d = S_WAIT;
          end
        S_WAIT:
          if (rx_s) begin
            idle_d = idle_q + 4'd1;
            if (idle_q == 4'd10)
              state_d = S_IDLE;
          end else begin
            idle_d = '0;
          end
        default:
          state_d = S_IDLE;
      endcase
    end

    if (state_d != state_q)
      bcnt_d = '0;
    if (state_d == S_WAIT && state_q != S_WAIT)
      idle_d = '0;
  end

`ifdef CAN_RX_ACK_EN
  logic tx_q;

  // ACK state spans exactly one bit boundary: the start of the ACK slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tx_q <= 1'b1;
    else if (wrap)
      tx_q <= (state_q != S_ACK);
  end

  assign can_tx = tx_q;
`else
  assign can_tx = 1'b1;
`endif

  assign rx_id         = id_q;
  assign rx_dlc        = dlc_q;
  assign rx_data       = data_q;
  assign rx_data_valid = dv_q;
  assign frame_done    = done_q;
  assign crc_err       = crce_q;
  assign stuff_err     = stfe_q;
  assign form_err      = frme_q;

endmodule
